// File: rtl/core_avl_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// i_avl_bus : Avalon-MM style command/response bundle shared by the
//             requesters and the target port of core_avl_bus_arbiter.
//
//  master drives : address, read, write, byte_en, write_data,
//                  begin_burst_transfer, burst_count, resp_ready
//  slave drives  : request_ready, read_data, read_data_valid
// ---------------------------------------------------------------------------
interface i_avl_bus #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int BURST_W = 4
);
    logic [ADDR_W-1:0]   address;
    logic                read;
    logic                write;
    logic [DATA_W/8-1:0] byte_en;
    logic [DATA_W-1:0]   write_data;
    logic                begin_burst_transfer;
    logic [BURST_W-1:0]  burst_count;
    logic                request_ready;
    logic [DATA_W-1:0]   read_data;
    logic                read_data_valid;
    logic                resp_ready;

    modport master (
        output address, read, write, byte_en, write_data,
               begin_burst_transfer, burst_count, resp_ready,
        input  request_ready, read_data, read_data_valid
    );

    modport slave (
        input  address, read, write, byte_en, write_data,
               begin_burst_transfer, burst_count, resp_ready,
        output request_ready, read_data, read_data_valid
    );
endinterface

// File: rtl/core_avl_bus_arbiter.sv
// ---------------------------------------------------------------------------
// core_avl_bus_arbiter : two-requester to one-target Avalon arbiter.
//   s0 = instruction fetch, s1 = MA-stage LSU, m0 = shared memory port.
//   Commands pass through combinationally from the arbitration winner.
//   Write bursts lock the grant to their owner until the last beat.
//   An in-order FIFO of outstanding reads steers each response beat back
//   to the requester that issued the read.
//
// Ports
//   clk       : clock
//   rest      : asynchronous reset, active low
//   avl_s0    : requester 0 (fetch), slave side
//   avl_s1    : requester 1 (LSU), slave side
//   avl_m0    : shared target port, master side
//   err_resp  : sticky, response beat arrived with no outstanding read
// ---------------------------------------------------------------------------
module core_avl_bus_arbiter #(
    parameter int PRIORITY_MODE   = 0,
    parameter int MAX_OUTSTANDING = 4,
    parameter int BURST_W         = 4
) (
    input  logic     clk,
    input  logic     rest,
    i_avl_bus.slave  avl_s0,
    i_avl_bus.slave  avl_s1,
    i_avl_bus.master avl_m0,
    output logic     err_resp
);

    localparam int AW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(MAX_OUTSTANDING);

    typedef enum logic {ST_UNLOCKED, ST_WBURST} state_t;

    state_t             r_state, w_state_nxt;
    logic               r_owner, w_owner_nxt;
    logic [BURST_W-1:0] r_beats, w_beats_nxt;
    logic               r_rr,    w_rr_nxt;

    logic               r_fifo_id [MAX_OUTSTANDING];
    logic [BURST_W-1:0] r_fifo_n  [MAX_OUTSTANDING];
    logic [AW-1:0]      r_wp, r_rp;
    logic [AW:0]        r_count;
    logic [BURST_W-1:0] r_head_done;
    logic               r_err;

    logic               w_full, w_empty;
    logic               w_el0, w_el1;
    logic               w_gnt_valid, w_gnt_id;
    logic               w_sel_read, w_sel_write, w_sel_bbt, w_sel_read_eff;
    logic [BURST_W-1:0] w_sel_bc, w_n;
    logic               w_accept, w_push, w_pop;
    logic               w_rsp_valid, w_rsp_hit, w_head_id, w_head_last;
    logic               w_unused;

    // Requester resp_ready is not used: requesters must always sink responses.
    assign w_unused = &{1'b0, avl_s0.resp_ready, avl_s1.resp_ready};

    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);

    // A read cannot be granted while the FIFO is full; writes always can.
    assign w_el0 = (avl_s0.read | avl_s0.write) & ~(avl_s0.read & w_full);
    assign w_el1 = (avl_s1.read | avl_s1.write) & ~(avl_s1.read & w_full);

    // ------------------------------------------------------------------
    // Arbitration. While a write burst is locked only the owner's writes
    // are forwarded; an owner read in that window is held back.
    // ------------------------------------------------------------------
    always_comb begin
        w_gnt_valid = 1'b0;
        w_gnt_id    = 1'b0;
        if (rest) begin
            if (r_state == ST_WBURST) begin
                w_gnt_id    = r_owner;
                w_gnt_valid = r_owner ? avl_s1.write : avl_s0.write;
            end else if (w_el0 && w_el1) begin
                w_gnt_valid = 1'b1;
                w_gnt_id    = (PRIORITY_MODE == 1) ? 1'b0 : r_rr;
            end else if (w_el0) begin
                w_gnt_valid = 1'b1;
                w_gnt_id    = 1'b0;
            end else if (w_el1) begin
                w_gnt_valid = 1'b1;
                w_gnt_id    = 1'b1;
            end
        end
    end

    assign w_sel_read     = w_gnt_id ? avl_s1.read  : avl_s0.read;
    assign w_sel_write    = w_gnt_id ? avl_s1.write : avl_s0.write;
    assign w_sel_bbt      = w_gnt_id ? avl_s1.begin_burst_transfer : avl_s0.begin_burst_transfer;
    assign w_sel_bc       = w_gnt_id ? avl_s1.burst_count : avl_s0.burst_count;
    assign w_sel_read_eff = w_sel_read & (r_state == ST_UNLOCKED);
    assign w_n            = (w_sel_bc == '0) ? BURST_W'(1) : w_sel_bc;

    assign w_accept = w_gnt_valid & avl_m0.request_ready;
    assign w_push   = w_accept & w_sel_read_eff;

    // ------------------------------------------------------------------
    // Command mux to m0
    // ------------------------------------------------------------------
    always_comb begin
        avl_m0.address              = '0;
        avl_m0.write_data           = '0;
        avl_m0.byte_en              = '0;
        avl_m0.begin_burst_transfer = 1'b0;
        avl_m0.burst_count          = '0;
        avl_m0.read                 = 1'b0;
        avl_m0.write                = 1'b0;
        if (w_gnt_valid) begin
            avl_m0.read  = w_sel_read_eff;
            avl_m0.write = w_sel_write;
            if (w_gnt_id) begin
                avl_m0.address              = avl_s1.address;
                avl_m0.write_data           = avl_s1.write_data;
                avl_m0.byte_en              = avl_s1.byte_en;
                avl_m0.begin_burst_transfer = avl_s1.begin_burst_transfer;
                avl_m0.burst_count          = avl_s1.burst_count;
            end else begin
                avl_m0.address              = avl_s0.address;
                avl_m0.write_data           = avl_s0.write_data;
                avl_m0.byte_en              = avl_s0.byte_en;
                avl_m0.begin_burst_transfer = avl_s0.begin_burst_transfer;
                avl_m0.burst_count          = avl_s0.burst_count;
            end
        end
    end

    assign avl_m0.resp_ready    = 1'b1;
    assign avl_s0.request_ready = w_gnt_valid & ~w_gnt_id & avl_m0.request_ready;
    assign avl_s1.request_ready = w_gnt_valid &  w_gnt_id & avl_m0.request_ready;

    // ------------------------------------------------------------------
    // Response routing from the FIFO head
    // ------------------------------------------------------------------
    assign w_rsp_valid = rest & avl_m0.read_data_valid;
    assign w_rsp_hit   = w_rsp_valid & ~w_empty;
    assign w_head_id   = r_fifo_id[r_rp];
    assign w_head_last = ((r_head_done + 1'b1) == r_fifo_n[r_rp]);
    assign w_pop       = w_rsp_hit & w_head_last;

    assign avl_s0.read_data_valid = w_rsp_hit & ~w_head_id;
    assign avl_s1.read_data_valid = w_rsp_hit &  w_head_id;
    assign avl_s0.read_data       = (w_rsp_hit & ~w_head_id) ? avl_m0.read_data : '0;
    assign avl_s1.read_data       = (w_rsp_hit &  w_head_id) ? avl_m0.read_data : '0;

    assign err_resp = r_err;

    // ------------------------------------------------------------------
    // Lock FSM and round-robin pointer: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_beats_nxt = r_beats;
        w_rr_nxt    = r_rr;
        if (w_accept) begin
            if (r_state == ST_UNLOCKED) begin
                w_rr_nxt = ~w_gnt_id;
                if (w_sel_write && w_sel_bbt && (w_n > BURST_W'(1))) begin
                    w_state_nxt = ST_WBURST;
                    w_owner_nxt = w_gnt_id;
                    w_beats_nxt = w_n - 1'b1;
                end
            end else begin
                w_beats_nxt = r_beats - 1'b1;
                if (r_beats == BURST_W'(1)) begin
                    w_state_nxt = ST_UNLOCKED;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            r_state <= ST_UNLOCKED;
            r_owner <= 1'b0;
            r_beats <= '0;
            r_rr    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_beats <= w_beats_nxt;
            r_rr    <= w_rr_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Outstanding-read FIFO and sticky error
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
                r_fifo_id[i] <= 1'b0;
                r_fifo_n[i]  <= '0;
            end
            r_wp        <= '0;
            r_rp        <= '0;
            r_count     <= '0;
            r_head_done <= '0;
            r_err       <= 1'b0;
        end else begin
            if (w_push) begin
                r_fifo_id[r_wp] <= w_gnt_id;
                r_fifo_n[r_wp]  <= w_n;
                r_wp            <= r_wp + 1'b1;
            end
            if (w_pop) begin
                r_rp <= r_rp + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_rsp_hit) begin
                r_head_done <= w_pop ? '0 : r_head_done + 1'b1;
            end
            if (w_rsp_valid && w_empty) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_core_avl_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_core_avl_bus_arbiter : directed self-checking bench for
// core_avl_bus_arbiter. u_rr uses round-robin, u_fp fixed priority.
// Inputs change on the falling edge; outputs are compared 1 ns later.
// ---------------------------------------------------------------------------
module tb_core_avl_bus_arbiter;

    logic clk;
    logic rest;
    logic err_rr, err_fp;
    int   n_cmp;
    int   n_bad;

    i_avl_bus s0_if ();
    i_avl_bus s1_if ();
    i_avl_bus m0_if ();
    i_avl_bus s0f_if ();
    i_avl_bus s1f_if ();
    i_avl_bus m0f_if ();

    core_avl_bus_arbiter #(.PRIORITY_MODE(0), .MAX_OUTSTANDING(4), .BURST_W(4)) u_rr (
        .clk(clk), .rest(rest), .avl_s0(s0_if), .avl_s1(s1_if), .avl_m0(m0_if), .err_resp(err_rr)
    );

    core_avl_bus_arbiter #(.PRIORITY_MODE(1), .MAX_OUTSTANDING(4), .BURST_W(4)) u_fp (
        .clk(clk), .rest(rest), .avl_s0(s0f_if), .avl_s1(s1f_if), .avl_m0(m0f_if), .err_resp(err_fp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        s0_if.read = 0; s0_if.write = 0; s0_if.address = '0; s0_if.byte_en = '1;
        s0_if.write_data = '0; s0_if.begin_burst_transfer = 0; s0_if.burst_count = 4'd1;
        s0_if.resp_ready = 1;
        s1_if.read = 0; s1_if.write = 0; s1_if.address = '0; s1_if.byte_en = '1;
        s1_if.write_data = '0; s1_if.begin_burst_transfer = 0; s1_if.burst_count = 4'd1;
        s1_if.resp_ready = 1;
        s0f_if.read = 0; s0f_if.write = 0; s0f_if.address = '0; s0f_if.byte_en = '1;
        s0f_if.write_data = '0; s0f_if.begin_burst_transfer = 0; s0f_if.burst_count = 4'd1;
        s0f_if.resp_ready = 1;
        s1f_if.read = 0; s1f_if.write = 0; s1f_if.address = '0; s1f_if.byte_en = '1;
        s1f_if.write_data = '0; s1f_if.begin_burst_transfer = 0; s1f_if.burst_count = 4'd1;
        s1f_if.resp_ready = 1;
        m0_if.request_ready = 1; m0_if.read_data = '0; m0_if.read_data_valid = 0;
        m0f_if.request_ready = 1; m0f_if.read_data = '0; m0f_if.read_data_valid = 0;
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if ({m0_if.read, m0_if.write, s0_if.request_ready, s1_if.request_ready} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %b want 0000",
                     {m0_if.read, m0_if.write, s0_if.request_ready, s1_if.request_ready});
        end
        n_cmp++;
        if ({s0_if.read_data_valid, s1_if.read_data_valid, err_rr, err_fp} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_rsp: got %b want 0000",
                     {s0_if.read_data_valid, s1_if.read_data_valid, err_rr, err_fp});
        end
    endtask

    task automatic test_rr_reads();
        @(negedge clk);
        s0_if.read = 1; s0_if.address = 32'h100;
        s1_if.read = 1; s1_if.address = 32'h200;
        #1;
        n_cmp++;
        if ({s0_if.request_ready, s1_if.request_ready, m0_if.read} !== 3'b101) begin
            n_bad++;
            $display("FAIL rr_c0_grant: got %b want 101",
                     {s0_if.request_ready, s1_if.request_ready, m0_if.read});
        end
        n_cmp++;
        if (m0_if.address !== 32'h100) begin
            n_bad++;
            $display("FAIL rr_c0_addr: got %0h want 100", m0_if.address);
        end
        @(negedge clk);
        s0_if.read = 0;
        #1;
        n_cmp++;
        if ({s0_if.request_ready, s1_if.request_ready, m0_if.address} !== {2'b01, 32'h200}) begin
            n_bad++;
            $display("FAIL rr_c1_grant: got %b/%0h want 01/200",
                     {s0_if.request_ready, s1_if.request_ready}, m0_if.address);
        end
        @(negedge clk);
        s1_if.read = 0;
        m0_if.read_data_valid = 1; m0_if.read_data = 32'hA5A5A5A5;
        #1;
        n_cmp++;
        if ({s0_if.read_data_valid, s1_if.read_data_valid, s0_if.read_data} !== {2'b10, 32'hA5A5A5A5}) begin
            n_bad++;
            $display("FAIL rr_rsp0: got %b/%0h want 10/a5a5a5a5",
                     {s0_if.read_data_valid, s1_if.read_data_valid}, s0_if.read_data);
        end
        @(negedge clk);
        m0_if.read_data = 32'h5A5A5A5A;
        #1;
        n_cmp++;
        if ({s0_if.read_data_valid, s1_if.read_data_valid, s1_if.read_data} !== {2'b01, 32'h5A5A5A5A}) begin
            n_bad++;
            $display("FAIL rr_rsp1: got %b/%0h want 01/5a5a5a5a",
                     {s0_if.read_data_valid, s1_if.read_data_valid}, s1_if.read_data);
        end
        @(negedge clk);
        idle();
        #1;
        n_cmp++;
        if (err_rr !== 1'b0) begin
            n_bad++;
            $display("FAIL rr_no_err: got %b want 0", err_rr);
        end
    endtask

    task automatic test_write_burst_lock();
        @(negedge clk);
        s1_if.write = 1; s1_if.begin_burst_transfer = 1; s1_if.burst_count = 4'd4;
        s1_if.write_data = 32'hD0;
        #1;
        n_cmp++;
        if ({s1_if.request_ready, m0_if.write, m0_if.burst_count} !== {2'b11, 4'd4}) begin
            n_bad++;
            $display("FAIL wb_beat1: got %b/%0d want 11/4",
                     {s1_if.request_ready, m0_if.write}, m0_if.burst_count);
        end
        @(negedge clk);
        s1_if.begin_burst_transfer = 0; s1_if.write_data = 32'hD1;
        #1;
        n_cmp++;
        if ({s1_if.request_ready, m0_if.write_data} !== {1'b1, 32'hD1}) begin
            n_bad++;
            $display("FAIL wb_beat2: got %b/%0h want 1/d1", s1_if.request_ready, m0_if.write_data);
        end
        // target stalls with beat 3 pending; s0 read appears
        @(negedge clk);
        m0_if.request_ready = 0; s1_if.write_data = 32'hD2; s0_if.read = 1; s0_if.address = 32'h300;
        #1;
        n_cmp++;
        if ({s0_if.request_ready, s1_if.request_ready, m0_if.read, m0_if.write} !== 4'b0001) begin
            n_bad++;
            $display("FAIL wb_stall: got %b want 0001",
                     {s0_if.request_ready, s1_if.request_ready, m0_if.read, m0_if.write});
        end
        @(negedge clk);
        m0_if.request_ready = 1;
        #1;
        n_cmp++;
        if ({s0_if.request_ready, s1_if.request_ready, m0_if.read} !== 3'b010) begin
            n_bad++;
            $display("FAIL wb_beat3: got %b want 010",
                     {s0_if.request_ready, s1_if.request_ready, m0_if.read});
        end
        @(negedge clk);
        s1_if.write_data = 32'hD3;
        #1;
        n_cmp++;
        if ({s0_if.request_ready, s1_if.request_ready, m0_if.write_data} !== {2'b01, 32'hD3}) begin
            n_bad++;
            $display("FAIL wb_beat4: got %b/%0h want 01/d3",
                     {s0_if.request_ready, s1_if.request_ready}, m0_if.write_data);
        end
        @(negedge clk);
        s1_if.write = 0;
        #1;
        n_cmp++;
        if ({s0_if.request_ready, m0_if.read, m0_if.address} !== {2'b11, 32'h300}) begin
            n_bad++;
            $display("FAIL wb_unlock_read: got %b/%0h want 11/300",
                     {s0_if.request_ready, m0_if.read}, m0_if.address);
        end
        @(negedge clk);
        s0_if.read = 0; m0_if.read_data_valid = 1; m0_if.read_data = 32'h33;
        #1;
        n_cmp++;
        if ({s0_if.read_data_valid, s1_if.read_data_valid} !== 2'b10) begin
            n_bad++;
            $display("FAIL wb_read_rsp: got %b want 10", {s0_if.read_data_valid, s1_if.read_data_valid});
        end
        @(negedge clk);
        idle();
    endtask

    task automatic test_fifo_full();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            s0_if.read = 1; s0_if.address = 32'h400 + k;
            #1;
            n_cmp++;
            if (s0_if.request_ready !== 1'b1) begin
                n_bad++;
                $display("FAIL ff_fill%0d: got %b want 1", k, s0_if.request_ready);
            end
        end
        @(negedge clk);
        s0_if.address = 32'h4F0;
        s1_if.write = 1; s1_if.write_data = 32'hEE;
        #1;
        n_cmp++;
        if ({s0_if.request_ready, s1_if.request_ready, m0_if.write, m0_if.read} !== 4'b0110) begin
            n_bad++;
            $display("FAIL ff_full_write: got %b want 0110",
                     {s0_if.request_ready, s1_if.request_ready, m0_if.write, m0_if.read});
        end
        @(negedge clk);
        s1_if.write = 0; m0_if.read_data_valid = 1; m0_if.read_data = 32'h40;
        #1;
        n_cmp++;
        if ({s0_if.request_ready, s0_if.read_data_valid} !== 2'b01) begin
            n_bad++;
            $display("FAIL ff_pop_same_cycle: got %b want 01", {s0_if.request_ready, s0_if.read_data_valid});
        end
        @(negedge clk);
        m0_if.read_data_valid = 0;
        #1;
        n_cmp++;
        if ({s0_if.request_ready, m0_if.address} !== {1'b1, 32'h4F0}) begin
            n_bad++;
            $display("FAIL ff_fifth: got %b/%0h want 1/4f0", s0_if.request_ready, m0_if.address);
        end
        @(negedge clk);
        s0_if.read = 0;
        for (int k = 0; k < 4; k++) begin
            m0_if.read_data_valid = 1;
            #1;
            n_cmp++;
            if ({s0_if.read_data_valid, s1_if.read_data_valid} !== 2'b10) begin
                n_bad++;
                $display("FAIL ff_drain%0d: got %b want 10", k, {s0_if.read_data_valid, s1_if.read_data_valid});
            end
            @(negedge clk);
        end
        idle();
    endtask

    task automatic test_burst_read_routing();
        @(negedge clk);
        s0_if.read = 1; s0_if.burst_count = 4'd8; s0_if.address = 32'h500;
        #1;
        n_cmp++;
        if (s0_if.request_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL br_s0_accept: got %b want 1", s0_if.request_ready);
        end
        @(negedge clk);
        s0_if.read = 0; s0_if.burst_count = 4'd1;
        s1_if.read = 1; s1_if.address = 32'h504;
        #1;
        n_cmp++;
        if (s1_if.request_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL br_s1_accept: got %b want 1", s1_if.request_ready);
        end
        @(negedge clk);
        s1_if.read = 0;
        for (int b = 1; b <= 9; b++) begin
            m0_if.read_data_valid = 1; m0_if.read_data = 32'h4000_0000 + b;
            #1;
            n_cmp++;
            if (b <= 8) begin
                if ({s0_if.read_data_valid, s1_if.read_data_valid, s0_if.read_data} !==
                    {2'b10, 32'h4000_0000 + b}) begin
                    n_bad++;
                    $display("FAIL br_beat%0d: got %b/%0h want 10/%0h", b,
                             {s0_if.read_data_valid, s1_if.read_data_valid}, s0_if.read_data, 32'h4000_0000 + b);
                end
            end else begin
                if ({s0_if.read_data_valid, s1_if.read_data_valid, s1_if.read_data} !==
                    {2'b01, 32'h4000_0009}) begin
                    n_bad++;
                    $display("FAIL br_beat9: got %b/%0h want 01/40000009",
                             {s0_if.read_data_valid, s1_if.read_data_valid}, s1_if.read_data);
                end
            end
            @(negedge clk);
        end
        idle();
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        s0_if.write = 1; s1_if.write = 1;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            n_cmp++;
            if ({s0_if.request_ready, s1_if.request_ready} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
                n_bad++;
                $display("FAIL b2b_rr%0d: got %b want %b", k,
                         {s0_if.request_ready, s1_if.request_ready}, (k % 2 == 0) ? 2'b10 : 2'b01);
            end
        end
        @(negedge clk);
        idle();
        s0f_if.write = 1; s0f_if.write_data = 32'h11;
        s1f_if.write = 1; s1f_if.write_data = 32'h22;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            n_cmp++;
            if ({s0f_if.request_ready, s1f_if.request_ready, m0f_if.write_data} !== {2'b10, 32'h11}) begin
                n_bad++;
                $display("FAIL b2b_fp%0d: got %b/%0h want 10/11", k,
                         {s0f_if.request_ready, s1f_if.request_ready}, m0f_if.write_data);
            end
        end
        @(negedge clk);
        idle();
    endtask

    task automatic test_reset_midop();
        @(negedge clk);
        s0_if.read = 1; s0_if.address = 32'h600;
        #1;
        n_cmp++;
        if (s0_if.request_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL rm_read0: got %b want 1", s0_if.request_ready);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (s0_if.request_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL rm_read1: got %b want 1", s0_if.request_ready);
        end
        @(negedge clk);
        rest = 0; m0_if.read_data_valid = 1; m0_if.read_data = 32'h66;
        #1;
        n_cmp++;
        if ({m0_if.read, m0_if.write, s0_if.request_ready, s1_if.request_ready,
             s0_if.read_data_valid, s1_if.read_data_valid, err_rr} !== 7'b0) begin
            n_bad++;
            $display("FAIL rm_in_reset: got %b want 0000000",
                     {m0_if.read, m0_if.write, s0_if.request_ready, s1_if.request_ready,
                      s0_if.read_data_valid, s1_if.read_data_valid, err_rr});
        end
        n_cmp++;
        if (m0_if.address !== 32'h0) begin
            n_bad++;
            $display("FAIL rm_addr: got %0h want 0", m0_if.address);
        end
        @(negedge clk);
        idle();
        rest = 1;
        @(negedge clk);
        m0_if.read_data_valid = 1; m0_if.read_data = 32'hDEAD;
        #1;
        n_cmp++;
        if ({s0_if.read_data_valid, s1_if.read_data_valid, err_rr} !== 3'b000) begin
            n_bad++;
            $display("FAIL rm_stray: got %b want 000", {s0_if.read_data_valid, s1_if.read_data_valid, err_rr});
        end
        @(negedge clk);
        m0_if.read_data_valid = 0;
        #1;
        n_cmp++;
        if (err_rr !== 1'b1) begin
            n_bad++;
            $display("FAIL rm_err_set: got %b want 1", err_rr);
        end
        repeat (3) @(negedge clk);
        s0_if.write = 1; s1_if.write = 1;
        #1;
        n_cmp++;
        if ({err_rr, s0_if.request_ready, s1_if.request_ready} !== 3'b110) begin
            n_bad++;
            $display("FAIL rm_sticky_ptr: got %b want 110", {err_rr, s0_if.request_ready, s1_if.request_ready});
        end
        @(negedge clk);
        idle();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rest  = 0;
        idle();
        repeat (2) @(negedge clk);
        test_reset();
        @(negedge clk);
        rest = 1;
        test_rr_reads();
        test_write_burst_lock();
        test_fifo_full();
        test_burst_read_routing();
        test_back_to_back();
        test_reset_midop();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
